// File: rtl/ex_iter_if.sv
// rtl/ex_iter_if.sv - decode-to-execute operand bundle and execute-stage result bundle
// The slave modport is the execute stage; the master is whatever drives it (id_ex or a bench).
interface ex_iter_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_iter.sv
// rtl/ex_iter.sv - execute stage: single-cycle logic/shift/arith plus iterative radix-2 DIV/DIVU
// The divider works on magnitudes and applies the sign fix-up only when presenting the result.
module ex_iter #(
  parameter int DIV_STEPS = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_iter_if.slave ex
);

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quot_q, quot_d;
  logic [31:0]     dvsr_q, dvsr_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;

  logic            is_div;
  logic            is_sdiv;
  logic [31:0]     abs1;
  logic [31:0]     abs2;
  logic [32:0]     shifted;
  logic            fits;
  logic [31:0]     alu_res;

  assign is_div  = (ex.aluop_i == OP_DIV) || (ex.aluop_i == OP_DIVU);
  assign is_sdiv = (ex.aluop_i == OP_DIV);
  assign abs1    = (is_sdiv && ex.reg1_i[31]) ? 32'd0 - ex.reg1_i : ex.reg1_i;
  assign abs2    = (is_sdiv && ex.reg2_i[31]) ? 32'd0 - ex.reg2_i : ex.reg2_i;

  // Restoring step: partial remainder always stays below the divisor, so 33 bits suffice.
  assign shifted = {rem_q, quot_q[31]};
  assign fits    = shifted >= {1'b0, dvsr_q};

  always_comb begin
    alu_res = '0;
    case (ex.alusel_i)
      SEL_LOGIC: begin
        case (ex.aluop_i)
          OP_AND:  alu_res = ex.reg1_i & ex.reg2_i;
          OP_OR:   alu_res = ex.reg1_i | ex.reg2_i;
          OP_XOR:  alu_res = ex.reg1_i ^ ex.reg2_i;
          OP_NOR:  alu_res = ~(ex.reg1_i | ex.reg2_i);
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (ex.aluop_i)
          OP_SLL:  alu_res = ex.reg2_i << ex.reg1_i[4:0];
          OP_SRL:  alu_res = ex.reg2_i >> ex.reg1_i[4:0];
          OP_SRA:  alu_res = 32'($signed(ex.reg2_i) >>> ex.reg1_i[4:0]);
          default: alu_res = '0;
        endcase
      end
      SEL_ARITH: begin
        case (ex.aluop_i)
          OP_ADDU: alu_res = ex.reg1_i + ex.reg2_i;
          OP_SUBU: alu_res = ex.reg1_i - ex.reg2_i;
          OP_SLT:  alu_res = {31'd0, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
          OP_SLTU: alu_res = {31'd0, ex.reg1_i < ex.reg2_i};
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ex.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (is_div) state_d = (ex.reg2_i == 32'd0) ? S_BYZERO : S_ON;
        S_BYZERO: state_d = is_div ? S_END : S_IDLE;
        S_ON: begin
          if (!is_div)                 state_d = S_IDLE;
          else if (count_q == LAST_STEP) state_d = S_END;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d    = count_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          count_d    = '0;
          rem_d      = '0;
          quot_d     = abs1;
          dvsr_d     = abs2;
          neg_quot_d = is_sdiv && (ex.reg1_i[31] ^ ex.reg2_i[31]);
          neg_rem_d  = is_sdiv && ex.reg1_i[31];
        end
      end
      S_ON: begin
        rem_d   = fits ? 32'(shifted - {1'b0, dvsr_q}) : shifted[31:0];
        quot_d  = {quot_q[30:0], fits};
        count_d = count_q + 1'b1;
      end
      S_BYZERO: begin
        rem_d  = '0;
        quot_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    ex.wd_o       = '0;
    ex.wreg_o     = 1'b0;
    ex.wdata_o    = '0;
    ex.whilo_o    = 1'b0;
    ex.hi_o       = '0;
    ex.lo_o       = '0;
    ex.stallreq_o = 1'b0;
    if (!rst) begin
      ex.wd_o    = ex.wd_i;
      ex.wreg_o  = is_div ? 1'b0 : ex.wreg_i;
      ex.wdata_o = alu_res;
      if (state_q == S_END) begin
        if (!ex.flush_i) begin
          ex.whilo_o = 1'b1;
          ex.lo_o    = neg_quot_q ? 32'd0 - quot_q : quot_q;
          ex.hi_o    = neg_rem_q  ? 32'd0 - rem_q  : rem_q;
        end
      end else begin
        ex.stallreq_o = is_div && !ex.flush_i;
      end
    end
  end

endmodule

// File: tb/tb_ex_iter.sv
// tb/tb_ex_iter.sv - directed and randomized checks of ex_iter against an arithmetic reference model
// Divide results come from the language's / and % operators; single-cycle results from plain expressions.
module tb_ex_iter;

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_NOP  = 8'b0000_0000;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  ex_iter_if itf ();

  ex_iter #(.DIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (itf.slave)
  );

  logic [7:0] op_tab  [0:11] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                 OP_SLT, OP_SLTU, OP_ADDU, OP_SUBU, OP_OR};
  logic [2:0] sel_tab [0:11] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_SHIFT,
                                 SEL_SHIFT, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH, 3'b111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    itf.aluop_i  = op;
    itf.alusel_i = sel;
    itf.reg1_i   = a;
    itf.reg2_i   = b;
    itf.wd_i     = wd;
    itf.wreg_i   = wreg;
  endtask

  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    if (sel == SEL_LOGIC && op == OP_AND)  return a & b;
    if (sel == SEL_LOGIC && op == OP_OR)   return a | b;
    if (sel == SEL_LOGIC && op == OP_XOR)  return a ^ b;
    if (sel == SEL_LOGIC && op == OP_NOR)  return ~(a | b);
    if (sel == SEL_SHIFT && op == OP_SLL)  return b << sh;
    if (sel == SEL_SHIFT && op == OP_SRL)  return b >> sh;
    if (sel == SEL_SHIFT && op == OP_SRA)  return 32'($signed(b) >>> sh);
    if (sel == SEL_ARITH && op == OP_ADDU) return a + b;
    if (sel == SEL_ARITH && op == OP_SUBU) return a - b;
    if (sel == SEL_ARITH && op == OP_SLT)  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (sel == SEL_ARITH && op == OP_SLTU) return (a < b) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Presents a divide in the current cycle (caller has already advanced to it) and runs it to END.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    int early;
    exp = model_div(sgn, a, b);
    drive(sgn ? OP_DIV : OP_DIVU, SEL_NOP, a, b, 5'd9, 1'b1);
    #1;
    n = 0;
    early = 0;
    while (itf.stallreq_o === 1'b1 && n < 100) begin
      if (itf.whilo_o !== 1'b0 || itf.wreg_o !== 1'b0) early++;
      step();
      #1;
      n++;
    end
    chk({tag, "_stalls"}, 32'(n), (b == 32'd0) ? 32'd2 : 32'd33);
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_whilo"}, {31'd0, itf.whilo_o}, 32'd1);
    chk({tag, "_lo"}, itf.lo_o, exp[31:0]);
    chk({tag, "_hi"}, itf.hi_o, exp[63:32]);
    chk({tag, "_wreg"}, {31'd0, itf.wreg_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int idx;
    int stray;
    logic wr;

    rst = 1'b1;
    itf.flush_i = 1'b0;
    drive(OP_OR, SEL_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
    #1;
    chk("rst_wdata", itf.wdata_o, 32'd0);
    chk("rst_ctrl", {23'd0, itf.wd_o, itf.wreg_o, itf.whilo_o, itf.stallreq_o}, 32'd0);
    chk("rst_hilo", itf.hi_o | itf.lo_o, 32'd0);
    step();
    step();
    rst = 1'b0;

    // T1: OR path
    drive(OP_OR, SEL_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
    #1;
    chk("t1_wdata", itf.wdata_o, 32'h0000_1111);
    chk("t1_wreg", {31'd0, itf.wreg_o}, 32'd1);
    chk("t1_wd", {27'd0, itf.wd_o}, 32'd3);
    chk("t1_stall", {31'd0, itf.stallreq_o}, 32'd0);
    chk("t1_whilo", {31'd0, itf.whilo_o}, 32'd0);

    // T2: SRA sign fill, signed vs unsigned compare
    step();
    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd4, 1'b1);
    #1;
    chk("t2_sra", itf.wdata_o, 32'hF800_0000);
    step();
    drive(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    #1;
    chk("t2_slt", itf.wdata_o, 32'd1);
    step();
    drive(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    #1;
    chk("t2_sltu", itf.wdata_o, 32'd0);

    // Randomized single-cycle ops; table entry 11 is an unknown class
    for (int i = 0; i < 40; i++) begin
      idx = int'($urandom_range(0, 11));
      a = $urandom;
      b = $urandom;
      wr = 1'($urandom_range(0, 1));
      step();
      drive(op_tab[idx], sel_tab[idx], a, b, 5'($urandom), wr);
      #1;
      chk("rand_alu_wdata", itf.wdata_o, model_alu(op_tab[idx], sel_tab[idx], a, b));
      chk("rand_alu_ctl", {30'd0, itf.wreg_o, itf.stallreq_o}, {30'd0, wr, 1'b0});
    end

    // T3..T5, back to back
    step();
    do_div("t3_divu", 1'b0, 32'd100, 32'd7);
    step();
    do_div("t4_div_neg", 1'b1, 32'hFFFF_FFF9, 32'd2);
    step();
    do_div("t4_div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    do_div("t5_div_zero", 1'b1, 32'd12345, 32'd0);

    // Randomized back-to-back divides, occasionally small or zero divisors
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i == 1) b = $urandom_range(1, 1000);
      step();
      do_div("rand_div", 1'($urandom_range(0, 1)), a, b);
    end

    // T6a: flush mid-divide
    step();
    drive(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd7, 1'b1);
    repeat (10) step();
    itf.flush_i = 1'b1;
    #1;
    chk("t6_flush_stall", {31'd0, itf.stallreq_o}, 32'd0);
    chk("t6_flush_whilo", {31'd0, itf.whilo_o}, 32'd0);
    step();
    itf.flush_i = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    stray = 0;
    repeat (36) begin
      step();
      if (itf.whilo_o !== 1'b0 || itf.stallreq_o !== 1'b0) stray++;
    end
    chk("t6_flush_quiet", 32'(stray), 32'd0);
    step();
    do_div("t6_after_flush", 1'b0, 32'hDEAD_BEEF, 32'd13);

    // T6b: reset mid-divide
    step();
    drive(OP_DIVU, SEL_NOP, 32'd5000, 32'd9, 5'd11, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {23'd0, itf.wd_o, itf.wreg_o, itf.whilo_o, itf.stallreq_o}, 32'd0);
    chk("t6_rst_data", itf.wdata_o | itf.hi_o | itf.lo_o, 32'd0);
    step();
    rst = 1'b0;
    do_div("t6_after_rst", 1'b1, 32'hFFFF_FF00, 32'd7);

    step();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    chk("end_whilo", {31'd0, itf.whilo_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
